// File: rtl/fetch_unit.sv
// PC generation and instruction buffer between the icache and the decoder.
// Holds the PC across icache refills and queues {pc, insn} for decode.
module fetch_unit #(
    parameter logic [63:0] RESET_PC    = 64'h0000_0000_0000_0000,
    parameter int unsigned QUEUE_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    output logic [62:0] core_req_pc,
    output logic        core_req_pc_valid,
    input  logic        icache_req_next_pc_rety,
    input  logic [31:0] core_ack_insn,
    input  logic        core_ack_insn_valid,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        dec_insn_valid,
    output logic [31:0] dec_insn,
    output logic [63:0] dec_pc,
    input  logic        dec_insn_ready
);
    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [62:0] pc;
        logic [31:0] insn;
    } entry_t;

    typedef enum logic {S_RUN, S_MISS} state_t;

    state_t             state_q, state_d;
    logic [62:0]        pc_q, pc_d;
    logic               pend_valid_q, pend_valid_d;
    logic [62:0]        pend_pc_q, pend_pc_d;
    entry_t             mem [QUEUE_DEPTH];
    logic [PTR_W-1:0]   rd_ptr_q, wr_ptr_q;
    logic [CNT_W-1:0]   count_q;
    logic               has_space, not_empty;
    logic               req_valid, enq, deq, flush;
    logic [62:0]        pc_inc;
    logic               unused_redirect_lsb;

    // PCs are kept in halfword units, so bit 0 of any byte address is dropped.
    assign unused_redirect_lsb = redirect_pc[0];

    assign has_space = count_q < CNT_W'(QUEUE_DEPTH);
    assign not_empty = count_q != '0;
    assign pc_inc    = pc_q + ((core_ack_insn[1:0] == 2'b11) ? 63'd2 : 63'd1);
    assign deq       = not_empty && dec_insn_ready;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        pend_valid_d = pend_valid_q;
        pend_pc_d    = pend_pc_q;
        req_valid    = 1'b0;
        enq          = 1'b0;
        flush        = 1'b0;
        case (state_q)
            S_RUN: begin
                req_valid = !redirect_valid && has_space;
                if (redirect_valid) begin
                    flush = 1'b1;
                    pc_d  = redirect_pc[63:1];
                end else if (req_valid && core_ack_insn_valid) begin
                    enq  = 1'b1;
                    pc_d = pc_inc;
                end else if (req_valid && icache_req_next_pc_rety) begin
                    state_d = S_MISS;
                end
            end
            S_MISS: begin
                // The icache tags the refill from the live PC, so it stays frozen here.
                req_valid = 1'b1;
                if (redirect_valid) begin
                    flush        = 1'b1;
                    pend_valid_d = 1'b1;
                    pend_pc_d    = redirect_pc[63:1];
                end
                if (core_ack_insn_valid) begin
                    state_d = S_RUN;
                    if (pend_valid_d) begin
                        pc_d         = pend_pc_d;
                        pend_valid_d = 1'b0;
                    end else begin
                        enq  = 1'b1;
                        pc_d = pc_inc;
                    end
                end
            end
            default: state_d = S_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_RUN;
            pc_q         <= RESET_PC[63:1];
            pend_valid_q <= 1'b0;
            pend_pc_q    <= '0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            pend_valid_q <= pend_valid_d;
            pend_pc_q    <= pend_pc_d;
            if (flush) begin
                rd_ptr_q <= '0;
                wr_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                if (enq) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
                if (deq) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
                count_q <= count_q + CNT_W'(enq) - CNT_W'(deq);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (enq) mem[wr_ptr_q] <= '{pc: pc_q, insn: core_ack_insn};
    end

    assign core_req_pc       = pc_q;
    assign core_req_pc_valid = req_valid && !reset;
    assign dec_insn_valid    = not_empty && !reset;
    assign dec_insn          = dec_insn_valid ? mem[rd_ptr_q].insn : '0;
    assign dec_pc            = dec_insn_valid ? {mem[rd_ptr_q].pc, 1'b0} : '0;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: vector table, directed miss/redirect/full sequences,
// then random traffic against a queue-based reference model.
module tb_fetch_unit;
    localparam logic [63:0] RST_PC = 64'h1000;
    localparam int          DEPTH  = 4;

    logic        clk, reset;
    logic [62:0] core_req_pc;
    logic        core_req_pc_valid;
    logic        icache_req_next_pc_rety;
    logic [31:0] core_ack_insn;
    logic        core_ack_insn_valid;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        dec_insn_valid;
    logic [31:0] dec_insn;
    logic [63:0] dec_pc;
    logic        dec_insn_ready;

    fetch_unit #(.RESET_PC(RST_PC), .QUEUE_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .core_req_pc(core_req_pc), .core_req_pc_valid(core_req_pc_valid),
        .icache_req_next_pc_rety(icache_req_next_pc_rety),
        .core_ack_insn(core_ack_insn), .core_ack_insn_valid(core_ack_insn_valid),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .dec_insn_valid(dec_insn_valid), .dec_insn(dec_insn), .dec_pc(dec_pc),
        .dec_insn_ready(dec_insn_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of fetched {pc, insn} plus the fetch address.
    typedef struct {
        logic [63:0] pc;
        logic [31:0] insn;
    } ent_t;
    ent_t        mq[$];
    logic [63:0] m_pc;
    bit          m_miss, m_pend;
    logic [63:0] m_pend_pc;

    function automatic bit m_req_valid();
        return m_miss ? 1'b1 : (!redirect_valid && mq.size() < DEPTH);
    endfunction

    task automatic model_reset();
        mq.delete();
        m_pc   = RST_PC & ~64'd1;
        m_miss = 0;
        m_pend = 0;
        m_pend_pc = '0;
    endtask

    task automatic check_model();
        chk("req_valid", core_req_pc_valid, m_req_valid());
        chk("req_pc", core_req_pc, m_pc >> 1);
        chk("dec_valid", dec_insn_valid, mq.size() != 0);
        if (mq.size() != 0) begin
            chk("dec_pc", dec_pc, mq[0].pc);
            chk("dec_insn", dec_insn, mq[0].insn);
        end else begin
            chk("dec_pc_idle", dec_pc, 64'd0);
            chk("dec_insn_idle", dec_insn, 64'd0);
        end
    endtask

    task automatic model_update();
        bit          hit, deq;
        logic [63:0] len;
        hit = m_req_valid() && core_ack_insn_valid;
        deq = mq.size() != 0 && dec_insn_ready;
        len = (core_ack_insn[1:0] == 2'b11) ? 64'd4 : 64'd2;
        if (!m_miss) begin
            if (redirect_valid) begin
                mq.delete();
                m_pc = redirect_pc & ~64'd1;
            end else begin
                if (deq) void'(mq.pop_front());
                if (hit) begin
                    mq.push_back('{pc: m_pc, insn: core_ack_insn});
                    m_pc = m_pc + len;
                end else if (m_req_valid() && icache_req_next_pc_rety) begin
                    m_miss = 1;
                end
            end
        end else begin
            if (redirect_valid) begin
                mq.delete();
                m_pend = 1;
                m_pend_pc = redirect_pc;
            end else if (deq) begin
                void'(mq.pop_front());
            end
            if (core_ack_insn_valid) begin
                if (m_pend) begin
                    m_pc = m_pend_pc & ~64'd1;
                    m_pend = 0;
                end else begin
                    mq.push_back('{pc: m_pc, insn: core_ack_insn});
                    m_pc = m_pc + len;
                end
                m_miss = 0;
            end
        end
    endtask

    task automatic set_in(input bit rv, input logic [63:0] rpc, input bit av,
                          input logic [31:0] ins, input bit rt, input bit rdy);
        @(negedge clk);
        reset                   = 1'b0;
        redirect_valid          = rv;
        redirect_pc             = rpc;
        core_ack_insn_valid     = av;
        core_ack_insn           = ins;
        icache_req_next_pc_rety = rt;
        dec_insn_ready          = rdy;
        #1;
    endtask

    task automatic finish_cyc();
        check_model();
        model_update();
        @(posedge clk);
    endtask

    task automatic do_reset();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            reset               = 1'b1;
            core_ack_insn_valid = 1'b1;
            core_ack_insn       = 32'h13;
            dec_insn_ready      = 1'b0;
            #1;
            chk("rst_req_valid", core_req_pc_valid, 64'd0);
            chk("rst_dec_valid", dec_insn_valid, 64'd0);
            chk("rst_dec_insn", dec_insn, 64'd0);
            chk("rst_dec_pc", dec_pc, 64'd0);
            @(posedge clk);
        end
        model_reset();
    endtask

    typedef struct {
        bit          rv;
        logic [63:0] rpc;
        bit          av;
        logic [31:0] ins;
        bit          rt;
        bit          rdy;
        bit          e_rv;
        logic [63:0] e_pc;
        bit          e_dv;
        logic [63:0] e_dpc;
        logic [31:0] e_din;
    } vec_t;

    vec_t tbl[9];
    int   n_bad_pc;

    initial begin
        reset = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        core_ack_insn_valid = 1'b0; core_ack_insn = '0;
        icache_req_next_pc_rety = 1'b0; dec_insn_ready = 1'b0;

        // Sequential fetch from reset, then mixed-length stream from 0x2000.
        tbl[0] = '{0, 64'h0,    1, 32'h13,       0, 1, 1, 64'h1000, 0, 64'h0,    32'h0};
        tbl[1] = '{0, 64'h0,    1, 32'h13,       0, 1, 1, 64'h1004, 1, 64'h1000, 32'h13};
        tbl[2] = '{0, 64'h0,    1, 32'h13,       0, 1, 1, 64'h1008, 1, 64'h1004, 32'h13};
        tbl[3] = '{1, 64'h2000, 0, 32'h0,        0, 1, 0, 64'h100C, 1, 64'h1008, 32'h13};
        tbl[4] = '{0, 64'h0,    1, 32'h4501,     0, 1, 1, 64'h2000, 0, 64'h0,    32'h0};
        tbl[5] = '{0, 64'h0,    1, 32'h00A00093, 0, 1, 1, 64'h2002, 1, 64'h2000, 32'h4501};
        tbl[6] = '{0, 64'h0,    1, 32'h8082,     0, 1, 1, 64'h2006, 1, 64'h2002, 32'h00A00093};
        tbl[7] = '{0, 64'h0,    0, 32'h0,        0, 1, 1, 64'h2008, 1, 64'h2006, 32'h8082};
        tbl[8] = '{0, 64'h0,    0, 32'h0,        0, 1, 1, 64'h2008, 0, 64'h0,    32'h0};

        do_reset();
        foreach (tbl[i]) begin
            set_in(tbl[i].rv, tbl[i].rpc, tbl[i].av, tbl[i].ins, tbl[i].rt, tbl[i].rdy);
            chk($sformatf("tbl%0d_req_valid", i), core_req_pc_valid, tbl[i].e_rv);
            chk($sformatf("tbl%0d_req_pc", i), core_req_pc, tbl[i].e_pc >> 1);
            chk($sformatf("tbl%0d_dec_valid", i), dec_insn_valid, tbl[i].e_dv);
            chk($sformatf("tbl%0d_dec_pc", i), dec_pc, tbl[i].e_dpc);
            chk($sformatf("tbl%0d_dec_insn", i), dec_insn, tbl[i].e_din);
            finish_cyc();
        end

        // Miss: five retries then a hit, PC held at 0x3020 throughout.
        set_in(1, 64'h3020, 0, 0, 0, 1); finish_cyc();
        for (int i = 0; i < 6; i++) begin
            set_in(0, 0, i == 5, 32'h13, i < 5, 1);
            chk("miss_req_valid", core_req_pc_valid, 64'd1);
            chk("miss_req_pc", core_req_pc, 64'h1810);
            finish_cyc();
        end
        n_bad_pc = 0;
        for (int i = 0; i < 4; i++) begin
            set_in(0, 0, 0, 0, 0, 1);
            if (dec_insn_valid && dec_pc == 64'h3020) n_bad_pc++;
            finish_cyc();
        end
        chk("miss_one_enqueue", n_bad_pc, 64'd1);

        // Redirect arriving in the second miss cycle with a non-empty FIFO.
        set_in(1, 64'h301C, 0, 0, 0, 0); finish_cyc();
        set_in(0, 0, 1, 32'h4501, 0, 0); finish_cyc();
        set_in(0, 0, 1, 32'h4501, 0, 0); finish_cyc();
        set_in(0, 0, 0, 0, 1, 0);
        chk("rmiss_req_pc1", core_req_pc, 64'h1810);
        finish_cyc();
        set_in(1, 64'h4001, 0, 0, 1, 0);
        chk("rmiss_req_valid", core_req_pc_valid, 64'd1);
        chk("rmiss_dec_valid_pre", dec_insn_valid, 64'd1);
        finish_cyc();
        set_in(0, 0, 1, 32'h13, 0, 1);
        chk("rmiss_flushed", dec_insn_valid, 64'd0);
        chk("rmiss_req_pc2", core_req_pc, 64'h1810);
        finish_cyc();
        n_bad_pc = 0;
        for (int i = 0; i < 4; i++) begin
            set_in(0, 0, 1, 32'h13, 0, 1);
            if (i == 0) begin
                chk("rmiss_new_pc", core_req_pc, 64'h2000);
                chk("rmiss_discard", dec_insn_valid, 64'd0);
            end
            if (dec_insn_valid && dec_pc == 64'h3020) n_bad_pc++;
            finish_cyc();
        end
        chk("rmiss_no_stale", n_bad_pc, 64'd0);

        // Full FIFO back-pressure and a single dequeue.
        set_in(1, 64'h5000, 0, 0, 0, 0); finish_cyc();
        for (int i = 0; i < 4; i++) begin
            set_in(0, 0, 1, 32'h13, 0, 0); finish_cyc();
        end
        set_in(0, 0, 1, 32'h13, 0, 1);
        chk("full_req_valid", core_req_pc_valid, 64'd0);
        chk("full_req_pc", core_req_pc, 64'h2808);
        chk("full_head", dec_pc, 64'h5000);
        finish_cyc();
        set_in(0, 0, 1, 32'h13, 0, 0);
        chk("full_resume", core_req_pc_valid, 64'd1);
        chk("full_head2", dec_pc, 64'h5004);
        finish_cyc();
        set_in(0, 0, 0, 0, 0, 0);
        chk("full_again", core_req_pc_valid, 64'd0);
        chk("full_req_pc2", core_req_pc, 64'h280A);
        finish_cyc();

        // Redirect in RUN with simultaneous hit and dequeue.
        set_in(1, 64'h8000, 1, 32'h13, 0, 1);
        chk("rrun_suppress", core_req_pc_valid, 64'd0);
        finish_cyc();
        set_in(0, 0, 0, 0, 0, 1);
        chk("rrun_empty", dec_insn_valid, 64'd0);
        chk("rrun_pc", core_req_pc, 64'h4000);
        finish_cyc();

        // PC wrap at the top of the address space; bit 0 of redirect ignored.
        set_in(1, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0, 1); finish_cyc();
        set_in(0, 0, 1, 32'h0001, 0, 1);
        chk("wrap_top", core_req_pc, 64'h7FFF_FFFF_FFFF_FFFF);
        finish_cyc();
        set_in(0, 0, 0, 0, 0, 1);
        chk("wrap_zero", core_req_pc, 64'd0);
        chk("wrap_dec_pc", dec_pc, 64'hFFFF_FFFF_FFFF_FFFE);
        finish_cyc();

        // Reset while in MISS returns to RUN at the reset PC.
        set_in(0, 0, 0, 0, 1, 1); finish_cyc();
        do_reset();
        set_in(0, 0, 0, 0, 0, 1);
        chk("post_rst_valid", core_req_pc_valid, 64'd1);
        chk("post_rst_pc", core_req_pc, 64'h800);
        finish_cyc();

        // Random traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            bit          rv, av, rt, rdy;
            logic [63:0] rpc;
            logic [31:0] ins;
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
                continue;
            end
            rv  = $urandom_range(0, 15) == 0;
            case ($urandom_range(0, 2))
                0:       rpc = {$urandom, $urandom};
                1:       rpc = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
                default: rpc = 64'($urandom_range(0, 255));
            endcase
            rt  = $urandom_range(0, 4) == 0;
            av  = !rt && !rv && $urandom_range(0, 1);
            ins = $urandom;
            rdy = $urandom_range(0, 2) != 0;
            set_in(rv, rpc, av, ins, rt, rdy);
            finish_cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
